fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for Core101. It owns the program counter and issues in-order 32-bit word reads to instruction memory. Returned words are buffered in a small queue together with their PCs, and each instruction is presented to decode and the immediate generator over a valid/ready handshake. Redirects from branch/jump resolution flush the queue and discard any reads still in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, number of queue entries. Power of two, ≥2. This is also the maximum number of outstanding requests.

Ports:
- clock_input, in, 1, single clock. All logic is on its rising edge.
- reset_input, in, 1, reset. Synchronous and active-high.
- mem_req_valid_output, out, 1, read request valid.
- mem_req_addr_output, out, 32, word-aligned read address (bits [1:0] are always 0).
- mem_req_ready_input, in, 1, memory accepts the request.
- mem_rsp_valid_input, in, 1, read data valid. Responses return in order and cannot be backpressured.
- mem_rsp_data_input, in, 32, read data.
- redirect_valid_input, in, 1, PC redirect.
- redirect_addr_input, in, 32, redirect target.
- ins_valid_output, out, 1, instruction available.
- ins_output, out, 32, instruction word. Feeds decode and the immediate generator's ins_input.
- ins_pc_output, out, 32, PC of ins_output.
- ins_ready_input, in, 1, consumer takes the instruction.
- misalign_output, out, 1, present only with FETCH_MISALIGN_CHECK_EN.

## Operation
- **Queue entry:** {pc, ins, filled}.
- **Issue:** mem_req_valid_output = !reset_input && reserved < DEPTH && discard_cnt == 0 (&& !misalign when the check is enabled).
  - It is driven only from registered state. It must not depend combinationally on redirect or ready inputs.
- **On request handshake:**
  - Reserve a tail entry with pc = PC and filled = 0.
  - PC ← PC + 4, wrapping modulo 2^32.
- **Response handling:**
  - If discard_cnt > 0: drop the data and decrement discard_cnt.
  - Otherwise: write the data into the oldest unfilled entry and set its filled bit.
  - A response arriving with no reserved-unfilled entry and discard_cnt == 0 is a protocol violation. It is ignored.
- **Output:** ins_valid_output = head entry filled. A pop occurs on ins_valid_output && ins_ready_input.
- **Redirect (highest priority):**
  - Next cycle the queue is empty and PC = redirect_addr_input with bits [1:0] cleared.
  - discard_cnt ← reserved-unfilled count, plus 1 if a request handshake happens this cycle, minus 1 if a response arrives this cycle and is not already being discarded.
  - A pop in the redirect cycle is legal; the popped instruction is delivered.
- **Simultaneous events:** reserve, fill and pop in the same cycle must all take effect; the reserved count changes by +1 −1 = 0.

## Timing
- **Reset values:** PC = RESET_PC; queue empty; discard_cnt = 0; mem_req_valid_output = 0 while reset_input = 1; ins_valid_output = 0; ins_output = 0; ins_pc_output = 0; misalign_output = 0.
- **Reset mid-operation:** clears all state. Responses arriving after reset are not tracked; the memory must also be reset.
- **First request:** the first cycle after reset deasserts, with address RESET_PC.
- **Latency:** request handshake at cycle N, response at N+L (L ≥ 1), ins_valid_output at N+L+1.
- **Throughput:** sustained one instruction per cycle requires DEPTH ≥ L+2. With DEPTH = 2 and L = 1, throughput is 2 instructions per 3 cycles.
- **After redirect:** issue resumes the cycle after discard_cnt reaches 0. If nothing was in flight, it resumes on the cycle after the redirect.

## Configuration
- **FETCH_MISALIGN_CHECK_EN defined:**
  - A redirect with addr[1:0] != 0 sets a registered misalign flag, driven on misalign_output.
  - While the flag is set, no requests issue.
  - The flag is cleared by an aligned redirect or by reset.
- **FETCH_MISALIGN_CHECK_EN undefined:**
  - The misalign_output port is absent.
  - addr[1:0] is silently cleared and fetch continues.

## Structure
- **Shared package / header:** default RESET_PC, the queue entry field widths, and the pointer width function log2(DEPTH).
- **Sub-module `fetch_queue`:**
  - A circular buffer with separate reserve, fill and pop pointers, a flush input, and a reserved-unfilled count output.
  - `fetch_unit` holds the PC, issue logic, discard counter and misalign flag.

## Test plan
- **Reset then fetch:** reset, memory with L = 1 and always ready, consumer always ready → requests at 0x0, 0x4, 0x8; instructions appear in order with matching PCs.
- **Backpressure:** ins_ready_input = 0 for 5 cycles → at most DEPTH requests outstanding or buffered; no instruction lost; order preserved after ready rises.
- **Redirect with 2 in flight:** L = 3, redirect to 0x100 → both stale responses dropped; next ins_pc_output = 0x100.
- **Redirect coinciding with request handshake and response:** discard_cnt computed correctly; no stale word is delivered.
- **Misaligned redirect to 0x102:**
  - Macro on: misalign_output = 1 and fetch halts.
  - Macro off: fetch resumes at 0x100.
- **PC wrap:** RESET_PC = 32'hFFFF_FFFC → second request address is 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the Core101 fetch stage: default reset PC, queue entry
// field widths and the queue pointer width helper.
package fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          PC_W             = 32;
  localparam int          INS_W            = 32;

  // Payload of one queue entry; the filled flag lives in a separate vector
  // because it is the only per-entry field that must be reset.
  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] ins;
  } entry_data_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction buffer with independent reserve, fill and pop pointers.
// Entries are reserved at request time and filled in order as responses return.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   reserve_i,
  input  logic [PC_W-1:0]        reserve_pc_i,
  input  logic                   fill_i,
  input  logic [INS_W-1:0]       fill_ins_i,
  input  logic                   pop_i,
  output logic                   head_valid_o,
  output logic [PC_W-1:0]        head_pc_o,
  output logic [INS_W-1:0]       head_ins_o,
  output logic [ptr_w(DEPTH):0]  count_o,
  output logic [ptr_w(DEPTH):0]  unfilled_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  entry_data_t      data_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    rsv_ptr_q, fill_ptr_q, pop_ptr_q;
  logic [CW-1:0]    count_q, count_d, unfilled_q, unfilled_d;
  logic             fill_ok, pop_ok;

  // A fill with nothing reserved-unfilled is a protocol violation and is dropped.
  assign fill_ok    = fill_i && (unfilled_q != '0);
  assign pop_ok     = pop_i && head_valid_o;
  assign count_d    = count_q + CW'(reserve_i) - CW'(pop_ok);
  assign unfilled_d = unfilled_q + CW'(reserve_i) - CW'(fill_ok);

  // NOTE: the payload array is deliberately not reset; validity comes only from
  // the reset pointers and filled flags, so stale payload is never observable.
  always_ff @(posedge clk_i) begin
    if (reserve_i) data_q[rsv_ptr_q].pc <= reserve_pc_i;
    if (fill_ok)   data_q[fill_ptr_q].ins <= fill_ins_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rsv_ptr_q  <= '0;
      fill_ptr_q <= '0;
      pop_ptr_q  <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
      filled_q   <= '0;
    end else begin
      // Reserve, fill and pop always target distinct slots, so all three can
      // land in the same cycle.
      if (reserve_i) begin
        filled_q[rsv_ptr_q] <= 1'b0;
        rsv_ptr_q           <= rsv_ptr_q + PW'(1);
      end
      if (fill_ok) begin
        filled_q[fill_ptr_q] <= 1'b1;
        fill_ptr_q           <= fill_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        filled_q[pop_ptr_q] <= 1'b0;
        pop_ptr_q           <= pop_ptr_q + PW'(1);
      end
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
    end
  end

  assign head_valid_o = filled_q[pop_ptr_q];
  assign head_pc_o    = head_valid_o ? data_q[pop_ptr_q].pc  : '0;
  assign head_ins_o   = head_valid_o ? data_q[pop_ptr_q].ins : '0;
  assign count_o      = count_q;
  assign unfilled_o   = unfilled_q;

endmodule

// File: rtl/fetch_unit.sv
// Core101 instruction fetch: PC, request issue, stale-response discard and queue.
// Optional misaligned-redirect trap is enabled with `define FETCH_MISALIGN_CHECK_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clock_input,
  input  logic        reset_input,
  output logic        mem_req_valid_output,
  output logic [31:0] mem_req_addr_output,
  input  logic        mem_req_ready_input,
  input  logic        mem_rsp_valid_input,
  input  logic [31:0] mem_rsp_data_input,
  input  logic        redirect_valid_input,
  input  logic [31:0] redirect_addr_input,
  output logic        ins_valid_output,
  output logic [31:0] ins_output,
  output logic [31:0] ins_pc_output,
  input  logic        ins_ready_input
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign_output
`endif
);

  localparam int CW = ptr_w(DEPTH) + 1;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   rsv_count, unfilled_count;
  logic            req_hs, pop, rsp_drop, rsp_accept, halt_misalign;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clock_input) begin
    if (reset_input)               misalign_q <= 1'b0;
    else if (redirect_valid_input) misalign_q <= |redirect_addr_input[1:0];
  end

  assign halt_misalign   = misalign_q;
  assign misalign_output = misalign_q;
`else
  logic unused_addr_bits;

  assign halt_misalign    = 1'b0;
  assign unused_addr_bits = ^redirect_addr_input[1:0];
`endif

  // Issue depends only on registered state (plus reset), never on same-cycle inputs.
  assign mem_req_valid_output = !reset_input && (rsv_count != CW'(DEPTH)) &&
                                (discard_q == '0) && !halt_misalign;
  assign mem_req_addr_output  = pc_q;

  assign req_hs     = mem_req_valid_output && mem_req_ready_input;
  assign pop        = ins_valid_output && ins_ready_input;
  assign rsp_drop   = mem_rsp_valid_input && (discard_q != '0);
  assign rsp_accept = mem_rsp_valid_input && (discard_q == '0) && (unfilled_count != '0);

  // NOTE: every variable gets its default before any branch so no latch is inferred.
  always_comb begin
    pc_d      = pc_q;
    discard_d = discard_q - CW'(rsp_drop);
    if (req_hs) pc_d = pc_q + 32'd4;
    if (redirect_valid_input) begin
      // Everything still in flight after this cycle becomes stale.
      pc_d      = {redirect_addr_input[31:2], 2'b00};
      discard_d = discard_q - CW'(rsp_drop) + unfilled_count + CW'(req_hs) - CW'(rsp_accept);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock_input) begin
    if (reset_input) begin
      pc_q      <= {RESET_PC[31:2], 2'b00};
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i        (clock_input),
    .rst_i        (reset_input),
    .flush_i      (redirect_valid_input),
    .reserve_i    (req_hs),
    .reserve_pc_i (pc_q),
    .fill_i       (mem_rsp_valid_input && (discard_q == '0)),
    .fill_ins_i   (mem_rsp_data_input),
    .pop_i        (pop),
    .head_valid_o (ins_valid_output),
    .head_pc_o    (ins_pc_output),
    .head_ins_o   (ins_output),
    .count_o      (rsv_count),
    .unfilled_o   (unfilled_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory/consumer model with random
// latency, backpressure and redirects, plus directed literal expectations.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_input = 1'b1;
  logic        mem_req_valid_output, mem_req_ready_input = 1'b0;
  logic [31:0] mem_req_addr_output;
  logic        mem_rsp_valid_input = 1'b0;
  logic [31:0] mem_rsp_data_input = '0;
  logic        redirect_valid_input = 1'b0;
  logic [31:0] redirect_addr_input = '0;
  logic        ins_valid_output, ins_ready_input = 1'b0;
  logic [31:0] ins_output, ins_pc_output;
  logic        w_req_valid, w_ins_valid;
  logic [31:0] w_req_addr, w_ins, w_ins_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_output, w_misalign;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clock_input          (clk),
    .reset_input          (reset_input),
    .mem_req_valid_output (mem_req_valid_output),
    .mem_req_addr_output  (mem_req_addr_output),
    .mem_req_ready_input  (mem_req_ready_input),
    .mem_rsp_valid_input  (mem_rsp_valid_input),
    .mem_rsp_data_input   (mem_rsp_data_input),
    .redirect_valid_input (redirect_valid_input),
    .redirect_addr_input  (redirect_addr_input),
    .ins_valid_output     (ins_valid_output),
    .ins_output           (ins_output),
    .ins_pc_output        (ins_pc_output),
    .ins_ready_input      (ins_ready_input)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_output      (misalign_output)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) u_wrap (
    .clock_input          (clk),
    .reset_input          (reset_input),
    .mem_req_valid_output (w_req_valid),
    .mem_req_addr_output  (w_req_addr),
    .mem_req_ready_input  (1'b1),
    .mem_rsp_valid_input  (1'b0),
    .mem_rsp_data_input   (32'h0),
    .redirect_valid_input (1'b0),
    .redirect_addr_input  (32'h0),
    .ins_valid_output     (w_ins_valid),
    .ins_output           (w_ins),
    .ins_pc_output        (w_ins_pc),
    .ins_ready_input      (1'b1)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_output      (w_misalign)
`endif
  );

  int checks = 0, failures = 0, cyc = 0;

  // Memory model: pending responses in issue order, tagged with the fetch epoch.
  int          pend_due[$];
  logic [31:0] pend_addr[$];
  int          pend_ep[$];
  int          epoch = 0, last_due = 0;
  logic [31:0] exp_req = '0, exp_ins = '0;
  bit          mis_model = 0, prev_rst = 0;

  int          lat_min = 1, lat_max = 1, p_mem_rdy = 100, p_ins_rdy = 100, p_redir = 0;
  bit          rst_v = 1, force_redir = 0, redir_on_hs_rsp = 0, redir_fired = 0;
  logic [31:0] force_tgt = '0;
  bit          popped, hs_seen;
  logic [31:0] popped_pc, hs_addr;
  int          hs_cnt = 0, pop_cnt = 0;
  logic [31:0] req_log[$], pop_log[$], wrap_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    int          stale, lat, due;
    bit          rsp_now, will_redir;
    logic [31:0] tgt;
    @(negedge clk);
    cyc++;
    popped  = 0;
    hs_seen = 0;
    reset_input          = rst_v;
    redirect_valid_input = 1'b0;
    rsp_now = !rst_v && (pend_due.size() > 0) && (pend_due[0] == cyc);
    mem_rsp_valid_input  = rsp_now;
    mem_rsp_data_input   = rsp_now ? mem_word(pend_addr[0]) : $urandom;
    mem_req_ready_input  = ($urandom_range(99) < p_mem_rdy);
    ins_ready_input      = ($urandom_range(99) < p_ins_rdy);
    #1;
    if (rst_v) begin
      check("rst_req_valid", mem_req_valid_output, 1'b0);
      if (prev_rst) begin
        check("rst_ins_valid", ins_valid_output, 1'b0);
        check("rst_ins", ins_output, 32'h0);
        check("rst_ins_pc", ins_pc_output, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("rst_misalign", misalign_output, 1'b0);
`endif
      end
      pend_due.delete(); pend_addr.delete(); pend_ep.delete();
      epoch = 0; last_due = cyc; exp_req = '0; exp_ins = '0; mis_model = 0;
      prev_rst = 1;
      return;
    end
    prev_rst = 0;

    tgt = $urandom_range(32'h0FFF);
    if ($urandom_range(9) != 0) tgt[1:0] = 2'b00;
    will_redir = ($urandom_range(99) < p_redir);
    if (force_redir || (redir_on_hs_rsp && rsp_now && mem_req_valid_output && mem_req_ready_input)) begin
      tgt = force_tgt; will_redir = 1; force_redir = 0; redir_on_hs_rsp = 0; redir_fired = 1;
    end
    redirect_valid_input = will_redir;
    redirect_addr_input  = tgt;

    stale = 0;
    foreach (pend_ep[i]) if (pend_ep[i] != epoch) stale++;
    check("inflight_bound", 32'(pend_due.size() <= DEPTH), 32'h1);
    if (stale > 0) check("issue_during_discard", mem_req_valid_output, 1'b0);
    if (mis_model) check("issue_while_misaligned", mem_req_valid_output, 1'b0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misalign_flag", misalign_output, mis_model);
`endif
    if (rsp_now) begin
      void'(pend_due.pop_front()); void'(pend_addr.pop_front()); void'(pend_ep.pop_front());
    end
    if (mem_req_valid_output && mem_req_ready_input) begin
      check("req_addr", mem_req_addr_output, exp_req);
      lat = int'($urandom_range(lat_max, lat_min));
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      pend_due.push_back(due); pend_addr.push_back(mem_req_addr_output); pend_ep.push_back(epoch);
      last_due = due;
      exp_req  = exp_req + 32'd4;
      hs_seen = 1; hs_addr = mem_req_addr_output; hs_cnt++;
      req_log.push_back(mem_req_addr_output);
    end
    if (ins_valid_output && ins_ready_input) begin
      check("ins_pc", ins_pc_output, exp_ins);
      check("ins_word", ins_output, mem_word(exp_ins));
      popped = 1; popped_pc = ins_pc_output; pop_cnt++;
      pop_log.push_back(ins_pc_output);
      exp_ins = exp_ins + 32'd4;
    end
    if (will_redir) begin
      epoch++;
      exp_req = {tgt[31:2], 2'b00};
      exp_ins = {tgt[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_model = (tgt[1:0] != 2'b00);
`endif
    end
    if (w_req_valid && wrap_log.size() < 2) wrap_log.push_back(w_req_addr);
  endtask

  task automatic wait_first_pop(input string name, input logic [31:0] exp);
    for (int i = 0; i < 100; i++) begin
      step();
      if (popped) begin
        check(name, popped_pc, exp);
        return;
      end
    end
    checks++; failures++;
    $display("FAIL %s timeout actual=none expected=%0h", name, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) step();
    rst_v = 0;

    // Reset then fetch, L=1, everything ready.
    req_log.delete(); pop_log.delete();
    step();
    check("first_req_after_reset", hs_seen, 1'b1);
    check("first_req_addr", hs_addr, 32'h0);
    repeat (11) step();
    check("fetch_req_count", 32'(req_log.size() >= 3), 32'h1);
    check("fetch_pop_count", 32'(pop_log.size() >= 3), 32'h1);
    check("req_1", req_log[1], 32'h4);
    check("req_2", req_log[2], 32'h8);
    check("pop_0", pop_log[0], 32'h0);
    check("pop_1", pop_log[1], 32'h4);
    check("pop_2", pop_log[2], 32'h8);
    pop_cnt = 0;
    repeat (30) step();
    check("throughput_d2_l1", pop_cnt, 32'd20);
    check("wrap_log_count", 32'(wrap_log.size()), 32'd2);
    check("wrap_first_addr", wrap_log[0], 32'hFFFF_FFFC);
    check("wrap_second_addr", wrap_log[1], 32'h0000_0000);

    // Backpressure for 5 cycles.
    p_ins_rdy = 0; hs_cnt = 0;
    repeat (5) step();
    check("stall_req_bound", 32'(hs_cnt <= DEPTH), 32'h1);
    p_ins_rdy = 100; pop_cnt = 0;
    repeat (10) step();
    check("resume_after_stall", 32'(pop_cnt >= 3), 32'h1);

    // Redirect with two reads in flight, L=3.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && pend_due.size() != 2; i++) step();
    force_tgt = 32'h100; force_redir = 1;
    step();
    wait_first_pop("redirect_l3_pc", 32'h100);

    // Redirect in the same cycle as a request handshake and a response.
    lat_min = 1; lat_max = 1; redir_fired = 0;
    force_tgt = 32'h300; redir_on_hs_rsp = 1;
    for (int i = 0; i < 50 && !redir_fired; i++) step();
    check("hs_rsp_redirect_fired", redir_fired, 1'b1);
    wait_first_pop("hs_rsp_redirect_pc", 32'h300);

    // Misaligned redirect.
    force_tgt = 32'h102; force_redir = 1;
    step();
`ifdef FETCH_MISALIGN_CHECK_EN
    hs_cnt = 0;
    repeat (10) step();
    check("misalign_out_set", misalign_output, 1'b1);
    check("misalign_halts_fetch", hs_cnt, 32'd0);
    force_tgt = 32'h200; force_redir = 1;
    step();
    wait_first_pop("aligned_after_misalign", 32'h200);
`else
    wait_first_pop("misalign_cleared_pc", 32'h100);
`endif

    // Random traffic with a mid-run reset.
    for (int seg = 0; seg < 6; seg++) begin
      lat_min   = int'($urandom_range(1, 2));
      lat_max   = lat_min + int'($urandom_range(0, 3));
      p_mem_rdy = int'($urandom_range(40, 100));
      p_ins_rdy = int'($urandom_range(30, 100));
      p_redir   = 3;
      if (seg == 3) begin
        rst_v = 1; repeat (2) step(); rst_v = 0;
      end
      repeat (500) step();
    end
    p_redir = 0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
